// File: rtl/fdiv_monitor_if.sv
// fdiv_monitor_if: groups the control inputs and measurement outputs of the
// divided-clock monitor.
//   en, div_in, err_clr      : driven by the environment (master side)
//   period, high_time        : last measured period / high time, CNT_W bits
//   period_valid, locked, err: status from the monitor (slave side)
interface fdiv_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             en;
  logic             div_in;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             err;

  modport master (
    output en, div_in, err_clr,
    input  period, high_time, period_valid, locked, err
  );

  modport slave (
    input  en, div_in, err_clr,
    output period, high_time, period_valid, locked, err
  );
endinterface

// File: rtl/fdiv_monitor.sv
// fdiv_monitor: receive-side checker for a clock divider. The divided clock
// div_in is sampled as data in the fin domain; each period and its high time
// are measured in fin cycles, lock is declared after LOCK_CNT consecutive
// matching periods, and ratio/duty/stuck-clock faults raise a sticky err.
// Ports:
//   fin  : system clock, all logic on its rising edge
//   rst  : asynchronous reset, active-low
//   bus  : fdiv_monitor_if.slave (en, div_in, err_clr in;
//          period, high_time, period_valid, locked, err out, all registered)
module fdiv_monitor #(
  parameter int DIV_RATIO  = 4,
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = 3,
  parameter int CHECK_DUTY = 1
) (
  input logic          fin,
  input logic          rst,
  fdiv_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RATIO   = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0] HALF_LO = CNT_W'(DIV_RATIO / 2);
  localparam logic [CNT_W-1:0] HALF_HI = CNT_W'((DIV_RATIO + 1) / 2);
  localparam int               MW      = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0]    LOCK_TGT = MW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    MEAS   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // Saturating add of a single bit; the counter never wraps past all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic             b);
    logic [CNT_W-1:0] r;
    if (a == CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = a + CNT_W'(b);
    end
    return r;
  endfunction

  // A period matches on exact ratio; the duty check accepts either rounding
  // of half the ratio so odd ratios are handled.
  function automatic logic period_ok(input logic [CNT_W-1:0] per,
                                     input logic [CNT_W-1:0] hi);
    logic duty_ok;
    duty_ok = (hi == HALF_LO) || (hi == HALF_HI);
    return (per == RATIO) && ((CHECK_DUTY == 0) || duty_ok);
  endfunction

  state_t           state_r;
  logic             div_q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] hcnt_r;
  logic [MW-1:0]    match_cnt_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_time_r;
  logic             period_valid_r;
  logic             locked_r;
  logic             err_r;

  logic             rise_s;
  logic             active_s;
  logic             meas_s;
  logic             timeout_s;
  logic             match_s;
  logic             err_set_s;
  logic [MW-1:0]    match_inc_s;

  // The running counters are evaluated at the rise, so they hold exactly the
  // period being closed out on this edge.
  assign rise_s      = bus.div_in & ~div_q_r;
  assign active_s    = (state_r == MEAS) || (state_r == LOCKED);
  assign meas_s      = bus.en & active_s & rise_s;
  assign timeout_s   = bus.en & active_s & ~rise_s & (cnt_r == CNT_MAX);
  assign match_s     = period_ok(cnt_r, hcnt_r);
  assign match_inc_s = match_cnt_r + MW'(1);
  // Only lock loss and a stuck clock are errors; mismatches while still
  // acquiring lock just restart the match count.
  assign err_set_s   = timeout_s | (meas_s & (state_r == LOCKED) & ~match_s);

  // Measurement FSM, counters, sticky error and registered outputs.
  always_ff @(posedge fin or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      div_q_r        <= 1'b0;
      cnt_r          <= {CNT_W{1'b0}};
      hcnt_r         <= {CNT_W{1'b0}};
      match_cnt_r    <= {MW{1'b0}};
      period_r       <= {CNT_W{1'b0}};
      high_time_r    <= {CNT_W{1'b0}};
      period_valid_r <= 1'b0;
      locked_r       <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      div_q_r        <= bus.div_in;
      period_valid_r <= 1'b0;

      // A new error in the same cycle as err_clr keeps err set.
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (bus.err_clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end

      if (!bus.en) begin
        state_r     <= IDLE;
        locked_r    <= 1'b0;
        match_cnt_r <= {MW{1'b0}};
        cnt_r       <= {CNT_W{1'b0}};
        hcnt_r      <= {CNT_W{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            cnt_r       <= {CNT_W{1'b0}};
            hcnt_r      <= {CNT_W{1'b0}};
            locked_r    <= 1'b0;
            match_cnt_r <= {MW{1'b0}};
            state_r     <= ARM;
          end

          ARM: begin
            // The arming rise only starts the count; it closes no period.
            if (rise_s) begin
              cnt_r   <= CNT_W'(1);
              hcnt_r  <= CNT_W'(1);
              state_r <= MEAS;
            end else begin
              cnt_r   <= {CNT_W{1'b0}};
              hcnt_r  <= {CNT_W{1'b0}};
              state_r <= ARM;
            end
          end

          MEAS, LOCKED: begin
            if (rise_s) begin
              period_r       <= cnt_r;
              high_time_r    <= hcnt_r;
              period_valid_r <= 1'b1;
              cnt_r          <= CNT_W'(1);
              hcnt_r         <= CNT_W'(1);
              if (match_s) begin
                if (state_r == MEAS) begin
                  match_cnt_r <= match_inc_s;
                  if (match_inc_s == LOCK_TGT) begin
                    state_r  <= LOCKED;
                    locked_r <= 1'b1;
                  end else begin
                    state_r <= MEAS;
                  end
                end else begin
                  state_r <= LOCKED;
                end
              end else begin
                match_cnt_r <= {MW{1'b0}};
                locked_r    <= 1'b0;
                state_r     <= MEAS;
              end
            end else if (cnt_r == CNT_MAX) begin
              // Stuck div_in: drop lock and re-arm; keep the last measurement.
              locked_r    <= 1'b0;
              match_cnt_r <= {MW{1'b0}};
              cnt_r       <= {CNT_W{1'b0}};
              hcnt_r      <= {CNT_W{1'b0}};
              state_r     <= ARM;
            end else begin
              cnt_r  <= sat_add(cnt_r, 1'b1);
              hcnt_r <= sat_add(hcnt_r, bus.div_in);
            end
          end

          default: begin
            state_r     <= IDLE;
            locked_r    <= 1'b0;
            match_cnt_r <= {MW{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            hcnt_r      <= {CNT_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign bus.period       = period_r;
  assign bus.high_time    = high_time_r;
  assign bus.period_valid = period_valid_r;
  assign bus.locked       = locked_r;
  assign bus.err          = err_r;

endmodule

// File: tb/tb_fdiv_monitor.sv
// tb_fdiv_monitor: directed bench for fdiv_monitor. dut1 checks duty
// (CHECK_DUTY=1); dut0 gets the same stimulus with CHECK_DUTY=0.
module tb_fdiv_monitor;

  logic fin;
  logic rst;
  logic en;
  logic div_in;
  logic err_clr;

  int n_tests;
  int n_fail;

  logic       cap_pv;
  logic [7:0] cap_per;
  logic [7:0] cap_ht;
  logic       cap_lk;
  logic       cap_er;
  logic       cap_lk0;

  fdiv_monitor_if #(.CNT_W(8)) bus1 ();
  fdiv_monitor_if #(.CNT_W(8)) bus0 ();

  assign bus1.en      = en;
  assign bus1.div_in  = div_in;
  assign bus1.err_clr = err_clr;
  assign bus0.en      = en;
  assign bus0.div_in  = div_in;
  assign bus0.err_clr = err_clr;

  fdiv_monitor #(.DIV_RATIO(4), .CNT_W(8), .LOCK_CNT(3), .CHECK_DUTY(1)) dut1 (
    .fin (fin),
    .rst (rst),
    .bus (bus1.slave)
  );

  fdiv_monitor #(.DIV_RATIO(4), .CNT_W(8), .LOCK_CNT(3), .CHECK_DUTY(0)) dut0 (
    .fin (fin),
    .rst (rst),
    .bus (bus0.slave)
  );

  // fin clock, 10 time units per cycle.
  initial begin
    fin = 1'b0;
    forever #5 fin = ~fin;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive div_in, let one fin edge sample it, then settle 1 unit past it.
  task automatic step(input logic d);
    div_in = d;
    @(posedge fin);
    #1;
  endtask

  // One div_in period; outputs are captured right after the rising sample.
  task automatic dperiod(input int hi, input int lo);
    step(1'b1);
    cap_pv  = bus1.period_valid;
    cap_per = bus1.period;
    cap_ht  = bus1.high_time;
    cap_lk  = bus1.locked;
    cap_er  = bus1.err;
    cap_lk0 = bus0.locked;
    for (int i = 1; i < hi; i++) step(1'b1);
    for (int i = 0; i < lo; i++) step(1'b0);
  endtask

  // From IDLE with en=1: one cycle to ARM, arming rise, then three matches.
  task automatic lock_seq(input string tag);
    en = 1'b1;
    step(1'b0);
    dperiod(2, 2);
    check({tag, "_arm_pv"}, cap_pv, 1'b0);
    dperiod(2, 2);
    check({tag, "_m1_pv"}, cap_pv, 1'b1);
    check({tag, "_m1_per"}, cap_per, 8'd4);
    check({tag, "_m1_ht"}, cap_ht, 8'd2);
    check({tag, "_m1_lk"}, cap_lk, 1'b0);
    dperiod(2, 2);
    check({tag, "_m2_lk"}, cap_lk, 1'b0);
    step(1'b1);
    check({tag, "_m3_pv"}, bus1.period_valid, 1'b1);
    check({tag, "_m3_lk"}, bus1.locked, 1'b1);
    check({tag, "_m3_err"}, bus1.err, 1'b0);
    step(1'b1);
    check({tag, "_pv_pulse"}, bus1.period_valid, 1'b0);
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    en      = 1'b0;
    div_in  = 1'b0;
    err_clr = 1'b0;

    // Reset state.
    step(1'b0);
    step(1'b0);
    check("rst_period", bus1.period, 8'd0);
    check("rst_ht", bus1.high_time, 8'd0);
    check("rst_pv", bus1.period_valid, 1'b0);
    check("rst_lk", bus1.locked, 1'b0);
    check("rst_err", bus1.err, 1'b0);

    // Ideal divide-by-4 lock.
    rst = 1'b1;
    lock_seq("lock1");

    // Ratio fault while locked: one stretched low phase gives period 5.
    dperiod(2, 2);
    dperiod(2, 3);
    dperiod(2, 2);
    check("ratio_pv", cap_pv, 1'b1);
    check("ratio_per", cap_per, 8'd5);
    check("ratio_err", cap_er, 1'b1);
    check("ratio_lk", cap_lk, 1'b0);
    dperiod(2, 2);
    dperiod(2, 2);
    check("relock_m2_lk", cap_lk, 1'b0);
    dperiod(2, 2);
    check("relock_lk", cap_lk, 1'b1);
    check("relock_err", cap_er, 1'b1);

    // en drop while locked: lock goes next cycle, err and period retained.
    en = 1'b0;
    step(1'b1);
    check("en_lk", bus1.locked, 1'b0);
    check("en_err", bus1.err, 1'b1);
    check("en_pv", bus1.period_valid, 1'b0);
    check("en_per", bus1.period, 8'd4);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    en = 1'b1;
    step(1'b0);
    dperiod(2, 2);
    check("en_arm_pv", cap_pv, 1'b0);
    dperiod(2, 2);
    dperiod(2, 2);
    dperiod(2, 2);
    check("en_relock_lk", cap_lk, 1'b1);
    check("en_relock_err", cap_er, 1'b1);

    // Lone err_clr clears err on the next edge.
    err_clr = 1'b1;
    step(1'b1);
    err_clr = 1'b0;
    check("clr_err", bus1.err, 1'b0);
    check("clr_lk", bus1.locked, 1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);

    // err_clr together with a new mismatch: set wins.
    dperiod(2, 3);
    err_clr = 1'b1;
    step(1'b1);
    err_clr = 1'b0;
    check("setwin_err", bus1.err, 1'b1);
    check("setwin_lk", bus1.locked, 1'b0);
    check("setwin_per", bus1.period, 8'd5);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    dperiod(2, 2);
    dperiod(2, 2);
    dperiod(2, 2);
    check("setwin_relock", cap_lk, 1'b1);

    // Stuck clock: clear err, then hold div_in low after a rise.
    err_clr = 1'b1;
    step(1'b1);
    err_clr = 1'b0;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check("stuck_pre_err", bus1.err, 1'b0);
    // cnt is 4 here; it reaches 255 after 251 more lows, timeout on the next.
    n = 0;
    while (bus1.err !== 1'b1 && n < 400) begin
      step(1'b0);
      n++;
    end
    check("stuck_cycles", n, 252);
    check("stuck_err", bus1.err, 1'b1);
    check("stuck_lk", bus1.locked, 1'b0);
    check("stuck_per", bus1.period, 8'd4);
    check("stuck_ht", bus1.high_time, 8'd2);
    dperiod(2, 2);
    check("stuck_arm_pv", cap_pv, 1'b0);
    dperiod(2, 2);
    check("stuck_m1_per", cap_per, 8'd4);
    dperiod(2, 2);
    dperiod(2, 2);
    check("stuck_relock", cap_lk, 1'b1);

    // Duty fault 3 high / 1 low: no lock with duty check, lock without it.
    en      = 1'b0;
    err_clr = 1'b1;
    step(1'b0);
    err_clr = 1'b0;
    en      = 1'b1;
    step(1'b0);
    dperiod(3, 1);
    dperiod(3, 1);
    check("duty_pv", cap_pv, 1'b1);
    check("duty_per", cap_per, 8'd4);
    check("duty_ht", cap_ht, 8'd3);
    dperiod(3, 1);
    check("duty0_m2_lk", cap_lk0, 1'b0);
    dperiod(3, 1);
    check("duty0_lk", cap_lk0, 1'b1);
    dperiod(3, 1);
    check("duty_ht2", cap_ht, 8'd3);
    check("duty_lk", cap_lk, 1'b0);
    check("duty_err", cap_er, 1'b0);

    // Asynchronous reset mid-lock, with period_valid high at the drop.
    en = 1'b0;
    step(1'b0);
    lock_seq("lock2");
    step(1'b1);
    check("prerst_pv", bus1.period_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_period", bus1.period, 8'd0);
    check("arst_ht", bus1.high_time, 8'd0);
    check("arst_pv", bus1.period_valid, 1'b0);
    check("arst_lk", bus1.locked, 1'b0);
    check("arst_err", bus1.err, 1'b0);
    step(1'b0);
    step(1'b0);
    rst = 1'b1;
    lock_seq("lock3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
